// File: rtl/exp2_q4_16_if.sv
// rtl/exp2_q4_16_if.sv - request/result bundle for the exp2_q4_16 antilog block
//
// Signals
//   start_i  request pulse, sampled by the block only when idle
//   n_i      integer part of the exponent, 0..15
//   f_i      fractional part of the exponent; MSB weighs 2^-1
//   busy_o   block is working on an accepted request
//   done_o   one-cycle pulse; data_o is valid from this cycle on
//   data_o   result, unsigned Q16.16
// Modports
//   master   requester side (drives start_i/n_i/f_i)
//   slave    antilog block side (drives busy_o/done_o/data_o)

interface exp2_q4_16_if #(
   parameter int FRAC_W = 16
);
   logic              start_i;
   logic [3:0]        n_i;
   logic [FRAC_W-1:0] f_i;
   logic              busy_o;
   logic              done_o;
   logic [31:0]       data_o;

   modport master (
      output start_i, n_i, f_i,
      input  busy_o, done_o, data_o
   );

   modport slave (
      input  start_i, n_i, f_i,
      output busy_o, done_o, data_o
   );
endinterface

// File: rtl/exp2_q4_16.sv
// rtl/exp2_q4_16.sv - sequential antilog 2^(n+f), Q16.16 result
//
// Computes 2^f as the product of 2^(2^-k) over the set fraction bits k, one
// constant multiply per cycle, then scales by 2^n with a single shift.
// Inputs are in the same format the log2 block produces, so the two chain
// directly for log-domain processing.
//
// Parameters
//   FRAC_W   fraction width of f_i, also the number of MUL cycles
//   ACC_FB   fractional bits of the Q2.ACC_FB accumulator (17..30)
// Ports
//   clk_i    clock, rising edge
//   rst_i    synchronous reset, active high, wins over everything
//   bus      exp2_q4_16_if slave: start_i/n_i/f_i in, busy_o/done_o/data_o out

module exp2_q4_16 #(
   parameter int FRAC_W = 16,
   parameter int ACC_FB = 30
) (
   input  logic        clk_i,
   input  logic        rst_i,
   exp2_q4_16_if.slave bus
);

   localparam int KW = $clog2(FRAC_W + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [KW-1:0]     k;
   logic [31:0]       acc;
   logic [3:0]        ncap;
   logic [FRAC_W-1:0] fcap;
   logic [31:0]       data;
   logic              busy;
   logic              done;

   logic [31:0]       k_rom;
   logic [63:0]       prod;
   logic [47:0]       shifted;
   logic              unused_bits;

   // K[k] = round(2^(2^-k) * 2^30). Narrower accumulators take the table
   // shifted down. Past k=16 the factor is within a few ppm of 1.0 and is
   // treated as exactly 1.
   function automatic logic [31:0] rom_k(input logic [KW-1:0] idx);
      logic [31:0] k30;
      case (int'(idx))
         1:       k30 = 32'h5A82_799A;
         2:       k30 = 32'h4C1B_F829;
         3:       k30 = 32'h45CA_E0F2;
         4:       k30 = 32'h42D5_61B4;
         5:       k30 = 32'h4166_C34C;
         6:       k30 = 32'h40B2_68FA;
         7:       k30 = 32'h4058_F6A8;
         8:       k30 = 32'h402C_6BE9;
         9:       k30 = 32'h4016_321B;
         10:      k30 = 32'h400B_1818;
         11:      k30 = 32'h4005_8BCE;
         12:      k30 = 32'h4002_C5D8;
         13:      k30 = 32'h4001_62E8;
         14:      k30 = 32'h4000_B173;
         15:      k30 = 32'h4000_58B9;
         16:      k30 = 32'h4000_2C5D;
         default: k30 = 32'h4000_0000;
      endcase
      return k30 >> (30 - ACC_FB);
   endfunction

   assign k_rom   = rom_k(k);
   // acc and K both lie below 2^(ACC_FB+1), so the product fits in 63 bits
   // and the rescaled value fits back into 32.
   assign prod    = {32'd0, acc} * {32'd0, k_rom};
   // acc < 2^31 shifted by at most 15 stays below 2^46.
   assign shifted = {16'd0, acc} << ncap;

   assign unused_bits = ^{prod[63:ACC_FB+32], prod[ACC_FB-1:0],
                          shifted[47:ACC_FB+16], shifted[ACC_FB-17:0]};

   // state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start_i) state_nx = MUL;
         MUL:     if (k == KW'(FRAC_W)) state_nx = SHIFT;
         SHIFT:   state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         MUL:     busy = 1'b1;
         SHIFT:   busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // datapath
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc  <= '0;
         k    <= '0;
         ncap <= '0;
         fcap <= '0;
         data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start_i) begin
                  ncap <= bus.n_i;
                  fcap <= bus.f_i;
                  acc  <= 32'd1 << ACC_FB;
                  k    <= KW'(1);
               end
            end
            MUL: begin
               // fcap is shifted left each cycle so its MSB is always the
               // bit of weight 2^-k for the current k.
               if (fcap[FRAC_W-1]) begin
                  acc <= prod[ACC_FB +: 32];
               end
               fcap <= {fcap[FRAC_W-2:0], 1'b0};
               k    <= k + KW'(1);
            end
            SHIFT: begin
               data <= shifted[ACC_FB-16 +: 32];
            end
            default: ;
         endcase
      end
   end

   assign bus.busy_o = busy;
   assign bus.done_o = done;
   assign bus.data_o = data;

endmodule

// File: tb/tb_exp2_q4_16.sv
// tb/tb_exp2_q4_16.sv - directed self-checking bench for exp2_q4_16

module tb_exp2_q4_16;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   exp2_q4_16_if #(.FRAC_W(16)) bus ();

   exp2_q4_16 #(.FRAC_W(16), .ACC_FB(30)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp, input int tol);
      logic [31:0] diff;
      n_cmp++;
      diff = (got > exp) ? (got - exp) : (exp - got);
      if (diff > 32'(tol)) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (tol %0d)", tag, got, exp, tol);
      end
   endtask

   // Issue one request, scramble the operands after the accept edge, and wait
   // for done_o. lat counts edges from the accept edge to the done cycle.
   task automatic run_op(input logic [3:0] n, input logic [15:0] f,
                         output logic [31:0] res, output int lat);
      bus.start_i = 1'b1;
      bus.n_i     = n;
      bus.f_i     = f;
      tick();
      bus.start_i = 1'b0;
      bus.n_i     = 4'($urandom);
      bus.f_i     = 16'($urandom);
      check("busy_after_accept", 32'(bus.busy_o), 32'd1, 0);
      lat = 1;
      while (!bus.done_o && lat < 60) begin
         tick();
         lat++;
      end
      res = bus.data_o;
      tick();
      check("done_single_pulse", 32'(bus.done_o), 32'd0, 0);
   endtask

   typedef struct {
      logic [3:0]  n;
      logic [15:0] f;
      logic [31:0] exp;
      int          tol;
      string       tag;
   } vec_t;

   initial begin
      logic [31:0] res;
      int          lat;
      int          dones;
      vec_t        vecs[5];

      n_cmp = 0;
      n_err = 0;
      bus.start_i = 1'b0;
      bus.n_i     = '0;
      bus.f_i     = '0;

      // reset
      rst = 1'b1;
      tick();
      tick();
      check("rst_busy", 32'(bus.busy_o), 32'd0, 0);
      check("rst_done", 32'(bus.done_o), 32'd0, 0);
      check("rst_data", bus.data_o, 32'd0, 0);
      rst = 1'b0;

      // first request and latency
      run_op(4'd0, 16'h0000, res, lat);
      check("n0f0_latency", 32'(lat), 32'd18, 0);
      check("n0f0_data", res, 32'h0001_0000, 0);

      // powers of two
      for (int n = 0; n < 16; n++) begin
         run_op(4'(n), 16'h0000, res, lat);
         check($sformatf("pow2_n%0d", n), res, 32'h0001_0000 << n, 0);
         check($sformatf("pow2_lat_n%0d", n), 32'(lat), 32'd18, 0);
      end

      // fractional vectors
      vecs[0] = '{4'd0,  16'h8000, 32'h0001_6A09, 0,  "sqrt2"};
      vecs[1] = '{4'd4,  16'h4000, 32'h0013_06FE, 1,  "n4_f025"};
      vecs[2] = '{4'd0,  16'hC000, 32'h0001_AE8A, 1,  "n0_f075"};
      vecs[3] = '{4'd8,  16'h0001, 32'h0100_00B1, 2,  "n8_lsb"};
      vecs[4] = '{4'd15, 16'hFFFF, 32'hFFFF_4E8B, 64, "max"};
      foreach (vecs[i]) begin
         run_op(vecs[i].n, vecs[i].f, res, lat);
         check(vecs[i].tag, res, vecs[i].exp, vecs[i].tol);
      end

      // start held high with operands changing during busy
      bus.start_i = 1'b1;
      bus.n_i     = 4'd2;
      bus.f_i     = 16'h8000;
      tick();
      lat = 1;
      while (!bus.done_o && lat < 60) begin
         bus.n_i = 4'($urandom);
         bus.f_i = 16'($urandom);
         tick();
         lat++;
      end
      check("held_latency", 32'(lat), 32'd18, 0);
      check("held_data", bus.data_o, 32'h0005_A827, 0);
      check("held_busy_in_done", 32'(bus.busy_o), 32'd0, 0);
      bus.n_i = 4'd1;
      bus.f_i = 16'h0000;
      tick();
      check("held_no_accept_in_done", 32'(bus.busy_o), 32'd0, 0);
      tick();
      bus.start_i = 1'b0;
      check("held_accept_after_done", 32'(bus.busy_o), 32'd1, 0);
      check("held_output_hold", bus.data_o, 32'h0005_A827, 0);
      lat = 1;
      while (!bus.done_o && lat < 60) begin
         tick();
         lat++;
      end
      check("back2back_latency", 32'(lat), 32'd18, 0);
      check("back2back_data", bus.data_o, 32'h0002_0000, 0);
      tick();

      // abort in MUL at k=7
      bus.start_i = 1'b1;
      bus.n_i     = 4'd5;
      bus.f_i     = 16'hFFFF;
      tick();
      bus.start_i = 1'b0;
      for (int c = 1; c < 7; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", 32'(bus.busy_o), 32'd0, 0);
      check("abort_data", bus.data_o, 32'd0, 0);
      dones = 0;
      for (int c = 0; c < 25; c++) begin
         if (bus.done_o) dones++;
         tick();
      end
      check("abort_no_done", 32'(dones), 32'd0, 0);
      run_op(4'd3, 16'h0000, res, lat);
      check("after_abort_latency", 32'(lat), 32'd18, 0);
      check("after_abort_data", res, 32'h0008_0000, 0);

      // reset and start together
      rst = 1'b1;
      bus.start_i = 1'b1;
      tick();
      rst = 1'b0;
      bus.start_i = 1'b0;
      tick();
      check("rst_start_dropped", 32'(bus.busy_o), 32'd0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
